// File: rtl/pipelined_shifter.sv
// Pipelined N-bit shifter (SLL/SRL/SRA/ROR): one register stage per shift-amount bit,
// with a valid/ready handshake on both sides and a global stall under backpressure.
module pipelined_shifter #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_shamt,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data
);

  localparam int L   = $clog2(N);
  // Stage i keeps only the shamt bits still needed downstream (i+1..L-1), packed as a triangle.
  localparam int TRI = (L * (L - 1)) / 2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [L-1:0]   valid_r;
  logic [N-1:0]   data_r [L];
  logic [1:0]     op_r [L-1];
  logic [L-2:0]   sign_r;
  logic [TRI-1:0] shamt_r;
  logic [N-1:0]   nxt_data_s [L];
  logic           advance_s;
  logic           accept_s;

  function automatic int tri_off(input int i);
    return i * (L - 1) - (i * (i - 1)) / 2;
  endfunction

  function automatic logic [N-1:0] stage_shift(input logic [N-1:0] d, input logic [1:0] op,
                                               input logic sgn, input logic en, input int amt);
    logic [N-1:0] fill;
    logic [N-1:0] r;
    fill = {N{sgn}} << (N - amt);
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = (d >> amt) | fill;
      OP_ROR:  r = (d >> amt) | (d << (N - amt));
      default: r = d;
    endcase
    if (en) begin
      return r;
    end else begin
      return d;
    end
  endfunction

  assign advance_s = !valid_r[L-1] || out_ready;
  assign in_ready  = advance_s && !flush;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = valid_r[L-1];
  assign out_data  = data_r[L-1];

  // Per-stage shift: stage i shifts by 2^i when its shamt bit is set.
  always_comb begin
    nxt_data_s[0] = stage_shift(in_data, in_op, in_data[N-1], in_shamt[0], 1);
    for (int i = 1; i < L; i++) begin
      nxt_data_s[i] = stage_shift(data_r[i-1], op_r[i-1], sign_r[i-1],
                                  shamt_r[tri_off(i-1)], 1 << i);
    end
  end

  // Pipeline registers: global stall when the output is held, flush clears valids only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {L{1'b0}};
      sign_r  <= {(L-1){1'b0}};
      shamt_r <= {TRI{1'b0}};
      for (int i = 0; i < L; i++) begin
        data_r[i] <= {N{1'b0}};
      end
      for (int i = 0; i < L - 1; i++) begin
        op_r[i] <= 2'b00;
      end
    end else begin
      if (flush) begin
        valid_r <= {L{1'b0}};
      end else if (advance_s) begin
        valid_r <= {valid_r[L-2:0], accept_s};
      end else begin
        valid_r <= valid_r;
      end
      if (advance_s) begin
        for (int i = 0; i < L; i++) begin
          data_r[i] <= nxt_data_s[i];
        end
        op_r[0]          <= in_op;
        sign_r[0]        <= in_data[N-1];
        shamt_r[L-2:0]   <= in_shamt[L-1:1];
        for (int i = 1; i < L - 1; i++) begin
          op_r[i]   <= op_r[i-1];
          sign_r[i] <= sign_r[i-1];
          for (int j = 0; j < L - 1 - i; j++) begin
            shamt_r[tri_off(i) + j] <= shamt_r[tri_off(i-1) + 1 + j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: directed table and corner sequences at N=32,
// plus randomized streams with random backpressure at N=8, 32 and 64 against a reference model.
module tb_pipelined_shifter;
  localparam int N    = 32;
  localparam int L    = 5;
  localparam int NOPS = 10000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;

  int checks = 0;
  int errors = 0;
  bit rand_go = 1'b0;
  bit rand_done [3];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  pipelined_shifter #(.N(N)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the plain shift expressions evaluated on a w-bit operand.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int w,
                                            input logic [1:0] op, input int s);
    logic [63:0] mask, x, sx, r;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    x = d & mask;
    sx = x[w-1] ? (x | ~mask) : x;
    case (op)
      2'b00:   r = x << s;
      2'b01:   r = x >> s;
      2'b10:   r = $signed(sx) >>> s;
      default: r = (s == 0) ? x : ((x >> s) | (x << (w - s)));
    endcase
    return r & mask;
  endfunction

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_rand32(output logic [31:0] e);
    in_data  = $urandom();
    in_shamt = 5'($urandom_range(0, 31));
    in_op    = 2'($urandom_range(0, 3));
    e = 32'(ref_shift({32'd0, in_data}, 32, in_op, int'(in_shamt)));
  endtask

  initial begin
    vec_t        tbl [14];
    logic [31:0] e, held, xe;
    int          sent, got, stall_left;
    bit          stall_seen, stalling;

    tbl[0]  = '{32'h8000_00F0, 5'd4,  2'b10, 32'hF800_000F};
    tbl[1]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000};
    tbl[2]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
    tbl[3]  = '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000};
    tbl[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF};
    tbl[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF};
    tbl[6]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF};
    tbl[7]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF};
    tbl[8]  = '{32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456};
    tbl[9]  = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000};
    tbl[10] = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
    tbl[11] = '{32'hFFFF_FFFF, 5'd16, 2'b00, 32'hFFFF_0000};
    tbl[12] = '{32'h8000_0001, 5'd31, 2'b11, 32'h0000_0003};
    tbl[13] = '{32'h8000_0000, 5'd1,  2'b10, 32'hC000_0000};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = 32'd0; in_shamt = 5'd0; in_op = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    rst = 1'b0;
    #1 check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single SRA: visible after exactly L-1 further edges, for one cycle.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h8000_00F0; in_shamt = 5'd4; in_op = 2'b10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("lat_valid_%0d", k), {63'd0, out_valid}, {63'd0, (k == 4)});
      if (k == 4) check("lat_data", {32'd0, out_data}, 64'h0000_0000_F800_000F);
    end

    // Back-to-back table stream.
    idle(2);
    for (int c = 0; c < 14 + L + 1; c++) begin
      @(negedge clk);
      check($sformatf("tbl_valid_c%0d", c), {63'd0, out_valid}, {63'd0, (c >= L && c - L < 14)});
      if (c >= L && c - L < 14) check($sformatf("tbl%0d", c - L), {32'd0, out_data}, {32'd0, tbl[c-L].exp});
      if (c < 14) begin
        in_valid = 1'b1; in_data = tbl[c].d; in_shamt = tbl[c].s; in_op = tbl[c].op;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: 3-cycle stall at the first result of an 8-op stream.
    idle(2);
    exp_q.delete();
    sent = 0; got = 0; stall_left = 0; stall_seen = 1'b0; held = 32'd0;
    for (int it = 0; it < 60 && !(got == 8 && sent == 8); it++) begin
      @(negedge clk);
      if (out_valid && !stall_seen) begin
        stall_seen = 1'b1; stall_left = 3;
      end
      stalling  = (stall_left > 0);
      out_ready = !stalling;
      if (stalling) begin
        check("bp_valid_held", {63'd0, out_valid}, 64'd1);
        if (stall_left < 3) check("bp_data_stable", {32'd0, out_data}, {32'd0, held});
        held = out_data;
        stall_left--;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("bp_extra_result", 64'd1, 64'd0);
        else check($sformatf("bp_result%0d", got), {32'd0, out_data}, {32'd0, exp_q.pop_front()});
        got++;
      end
      if (sent < 8) begin
        in_valid = 1'b1;
        drive_rand32(e);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalling) check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(e);
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (L + 2) begin
      @(negedge clk);
      check("bp_no_dup", {63'd0, out_valid}, 64'd0);
    end
    check("bp_count", 64'(got), 64'd8);

    // Flush with a concurrent request, then a normal op afterwards.
    idle(2);
    xe = 32'd0;
    for (int c = 0; c < L + 6; c++) begin
      @(negedge clk);
      check($sformatf("fl_valid_c%0d", c), {63'd0, out_valid}, {63'd0, (c == 4 + L)});
      if (c == 4 + L) check("fl_after_data", {32'd0, out_data}, {32'd0, xe});
      flush = (c == 3);
      in_valid = (c <= 4);
      if (c <= 4) drive_rand32(e);
      if (c == 4) xe = e;
      #1;
      if (c == 3) check("fl_in_ready", {63'd0, in_ready}, 64'd0);
    end
    flush = 1'b0; in_valid = 1'b0;

    // Async reset between edges with ops in flight.
    idle(2);
    xe = 32'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      drive_rand32(e);
      if (c == 0) xe = e;
    end
    @(negedge clk);
    check("ar_pre_valid", {63'd0, out_valid}, 64'd1);
    check("ar_pre_data", {32'd0, out_data}, {32'd0, xe});
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check("ar_valid_drop", {63'd0, out_valid}, 64'd0);
    check("ar_data_zero", {32'd0, out_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1 check("ar_in_ready", {63'd0, in_ready}, 64'd1);
    for (int c = 0; c < L + 3; c++) begin
      @(negedge clk);
      check("ar_no_stale", {63'd0, out_valid}, 64'd0);
    end

    // Randomized regression across widths.
    rand_go = 1'b1;
    begin
      int budget;
      budget = 0;
      while (!(rand_done[0] && rand_done[1] && rand_done[2]) && budget < 50000) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 50000) check("rand_timeout", 64'd0, 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int W  = (g == 0) ? 8 : ((g == 1) ? 32 : 64);
    localparam int LW = $clog2(W);
    logic          r_iv, r_irdy, r_dv, r_ready;
    logic [W-1:0]  r_din, r_dout;
    logic [LW-1:0] r_sh;
    logic [1:0]    r_op;

    pipelined_shifter #(.N(W)) dut_r (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(r_iv), .in_ready(r_irdy),
      .in_data(r_din), .in_shamt(r_sh), .in_op(r_op), .out_valid(r_dv),
      .out_ready(r_ready), .out_data(r_dout)
    );

    initial begin
      logic [63:0] q [$];
      logic [63:0] rnd;
      int          sent, got, iter, s;
      r_iv = 1'b0; r_ready = 1'b1; r_din = '0; r_sh = '0; r_op = 2'b00;
      sent = 0; got = 0; iter = 0;
      wait (rand_go);
      while ((sent < NOPS || got < NOPS) && iter < 40000) begin
        @(negedge clk);
        iter++;
        r_ready = (sent >= NOPS) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (r_dv && r_ready) begin
          if (q.size() == 0) check($sformatf("rand%0d_extra", W), 64'd1, 64'd0);
          else check($sformatf("rand%0d_result%0d", W, got), 64'(r_dout), q.pop_front());
          got++;
        end
        r_iv = (sent < NOPS) && ($urandom_range(0, 3) != 0);
        rnd = {$urandom(), $urandom()};
        r_din = rnd[W-1:0];
        s = $urandom_range(0, W - 1);
        if ($urandom_range(0, 7) == 0) s = ($urandom_range(0, 1) == 0) ? 0 : W - 1;
        r_sh = LW'(s);
        r_op = 2'($urandom_range(0, 3));
        #1;
        check($sformatf("rand%0d_in_ready", W), {63'd0, r_irdy}, {63'd0, (!r_dv || r_ready)});
        if (r_iv && r_irdy) begin
          q.push_back(ref_shift(64'(r_din), W, r_op, s));
          sent++;
        end
      end
      r_iv = 1'b0;
      check($sformatf("rand%0d_count", W), 64'(got), 64'(NOPS));
      rand_done[g] = 1'b1;
    end
  end

endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Pipelined, parametrised N-bit shifter supporting logical left, logical right, arithmetic right and rotate-right in one datapath. It has one register stage per shift-amount bit, giving throughput of one operation per clock. A valid/ready handshake on both sides lets it sit between the register-file read stage and writeback, or in any streaming datapath, and stall cleanly under backpressure. It supersedes the single-mode combinational right shifter.

## Interface
- N, 32, data width; power of two, 8 to 64.
- L (localparam), $clog2(N), shift-amount width and pipeline depth.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; discards all in-flight operations.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block can accept an operation this cycle.
- in_data  input  N  operand.
- in_shamt  input  L  shift amount, 0 to N-1.
- in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  N  shifted result.

## Operation
- Stage i (0..L-1) holds a valid bit, data, op, shamt bits above i, and the original sign bit (in_data[N-1]).
- Stage i shifts its incoming data by 2^i when shamt bit i is set, and passes it unchanged otherwise. Fill depends on op:
  - SLL: fill LSBs with 0.
  - SRL: fill MSBs with 0.
  - SRA: fill MSBs with the captured sign bit.
  - ROR: bits shifted out of bit 0 re-enter at bit N-1.
- Stage 0 takes its input directly from the in_* ports. The last stage drives out_data and out_valid.
- advance = !out_valid || out_ready.
- in_ready = advance && !flush. This is combinational and has no dependence on in_valid.
- Acceptance occurs when in_valid && in_ready are both high at a rising edge.
- When advance is high, every stage loads from its predecessor. Stage 0 loads valid = acceptance.
- When advance is low, all stages hold their contents (global stall, no bubble collapse).
- A result leaves when out_valid && out_ready are both high at an edge.
- flush clears all valid bits at the edge and takes priority over acceptance. Data registers may keep stale contents.
- While out_valid is high and out_ready is low, out_data stays stable.
- Payload registers of invalid stages are don't-care. Verification checks out_data only while out_valid is high.

## Timing
- Reset (async assert): all valid bits go to 0, out_valid = 0, out_data = 0, and in_ready = 1 immediately after reset deasserts (given flush = 0).
- Latency: an operation accepted at edge E produces out_valid = 1 after edge E+L-1. For N = 32, L = 5, so the result is visible in the 5th cycle counted from the accepting cycle.
- Throughput: with out_ready held high, one result per cycle.
- Stall: if out_ready is low with out_valid high for k cycles, the whole pipe freezes for k cycles and nothing is lost or duplicated.
- Reset mid-operation: all in-flight operations are dropped. No result for them ever appears.
- Simultaneous flush and in_valid: in_ready is 0, nothing is accepted, and the pipe is empty after the edge.
- Simultaneous output handshake and new acceptance: both complete in the same cycle.
- shamt = 0: result equals in_data for all ops.
- Results are bit-exact against these expressions:
  - SLL: in << s
  - SRL: in >> s
  - SRA: $signed(in) >>> s
  - ROR: (in >> s) | (in << (N-s))
  - For ROR with s = 0, the result is in.

## Test plan
- Reset, then single SRA with N=32: in_data=0x8000_00F0, shamt=4 -> out_data=0xF800_000F, out_valid high exactly 5 cycles after acceptance, then low.
- Back-to-back stream with out_ready=1: SLL 0x1 by 31, SRL 0x8000_0000 by 31, ROR 0x0000_0001 by 1, SRL 0xDEAD_BEEF by 0 -> 0x8000_0000, 0x1, 0x8000_0000, 0xDEAD_BEEF on consecutive cycles.
- Backpressure: stream 8 ops, hold out_ready low for 3 cycles while out_valid is high -> in_ready low for those 3 cycles, out_data stable, all 8 results in order with no drops or duplicates.
- Flush: accept 3 ops, assert flush together with in_valid on the next cycle -> no out_valid for any of them; an op accepted after flush emerges normally.
- Async reset mid-stream: assert rst between edges with 4 ops in flight -> out_valid drops immediately, no stale result appears after release.
- Random regression: 10,000 random ops with random out_ready at N=8, 32 and 64 -> every result matches the reference expressions, in order.
